// File: rtl/direction_controller.sv
// direction_controller: synchronises, debounces and edge-detects four direction
// pushbuttons, filters repeats and (optionally) reversals, queues accepted
// presses and applies one queued direction per game step.
module direction_controller #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         QUEUE_DEPTH     = 2,
  parameter bit         ALLOW_REVERSE   = 1'b0,
  parameter logic [1:0] INIT_DIR        = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_pb,
  input  logic       down_pb,
  input  logic       left_pb,
  input  logic       right_pb,
  input  logic       step,
  output logic [1:0] dir,
  output logic       out_up,
  output logic       out_down,
  output logic       out_left,
  output logic       out_right,
  output logic       dir_changed,
  output logic [2:0] queue_count,
  output logic       drop
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int                PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [2:0]        DEPTH_C  = 3'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);

  // Button index equals its direction code: 0 up, 1 down, 2 left, 3 right.
  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       stable_q;
  logic [3:0]       events;
  logic [CNT_W-1:0] cnt [4];

  logic [1:0]       mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] tail_idx;
  logic [1:0]       tail;
  logic [1:0]       cand;
  logic             have_cand;
  logic             multi;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop_next;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  assign raw    = {right_pb, left_pb, down_pb, up_pb};
  assign events = stable & ~stable_q;

  // Two-stage synchroniser for the asynchronous buttons.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so sync2 samples the
    // previous sync1, forming a real two-flop chain rather than one flop.
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: accept a level only after it has differed for long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pick the candidate press, evaluate it against the queue tail, decide push/drop.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    cand      = 2'b00;
    have_cand = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (events[i]) begin
        cand      = 2'(i);
        have_cand = 1'b1;
      end
    end
    multi     = (events & (events - 4'd1)) != 4'd0;
    tail_idx  = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
    tail      = (queue_count != 3'd0) ? mem[tail_idx] : dir;
    full      = (queue_count == DEPTH_C);
    pop       = step && (queue_count != 3'd0);
    push      = have_cand
                && (cand != tail)
                && !((ALLOW_REVERSE == 1'b0) && (cand == (tail ^ 2'b01)))
                && !(full && !pop);
    drop_next = multi || (have_cand && !push);
  end

  // Queue storage; occupancy is tracked by queue_count, so stale slots are never read.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; clearing the pointers and count
    // is enough, and leaving it out keeps the array a plain register file.
    if (push) mem[wr_ptr] <= cand;
  end

  // Queue pointers, current direction and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= 3'd0;
      dir         <= INIT_DIR;
      {out_right, out_left, out_down, out_up} <= decode(INIT_DIR);
      dir_changed <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
        dir    <= mem[rd_ptr];
        {out_right, out_left, out_down, out_up} <= decode(mem[rd_ptr]);
      end
      queue_count <= queue_count + {2'b00, push} - {2'b00, pop};
      dir_changed <= pop;
      drop        <= drop_next;
    end
  end

endmodule

// File: tb/tb_direction_controller.sv
// Directed self-checking bench for direction_controller (DEBOUNCE_CYCLES=4,
// QUEUE_DEPTH=2, INIT_DIR=11). A second instance with reversals allowed shares
// all inputs and is checked only in the reversal scenario.
module tb_direction_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_pb, down_pb, left_pb, right_pb, step;

  logic [1:0] dir, r_dir;
  logic       out_up, out_down, out_left, out_right;
  logic       r_up, r_down, r_left, r_right;
  logic       dir_changed, r_dir_changed;
  logic [2:0] queue_count, r_queue_count;
  logic       drop, r_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  direction_controller #(
    .DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(2), .ALLOW_REVERSE(1'b0), .INIT_DIR(2'b11)
  ) dut (
    .clk(clk), .rst(rst),
    .up_pb(up_pb), .down_pb(down_pb), .left_pb(left_pb), .right_pb(right_pb),
    .step(step), .dir(dir),
    .out_up(out_up), .out_down(out_down), .out_left(out_left), .out_right(out_right),
    .dir_changed(dir_changed), .queue_count(queue_count), .drop(drop)
  );

  direction_controller #(
    .DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(2), .ALLOW_REVERSE(1'b1), .INIT_DIR(2'b11)
  ) dut_rev (
    .clk(clk), .rst(rst),
    .up_pb(up_pb), .down_pb(down_pb), .left_pb(left_pb), .right_pb(right_pb),
    .step(step), .dir(r_dir),
    .out_up(r_up), .out_down(r_down), .out_left(r_left), .out_right(r_right),
    .dir_changed(r_dir_changed), .queue_count(r_queue_count), .drop(r_drop)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a button mask {right,left,down,up}; after 8 edges the push/drop result is visible.
  task automatic press(input logic [3:0] mask);
    {right_pb, left_pb, down_pb, up_pb} = mask;
    repeat (8) tick();
  endtask

  task automatic release_all();
    {right_pb, left_pb, down_pb, up_pb} = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; step = 1'b0;
    {right_pb, left_pb, down_pb, up_pb} = 4'b0000;

    // Reset state
    repeat (3) tick();
    check("rst_dir", dir, 2'b11);
    check("rst_out_right", out_right, 1'b1);
    check("rst_other_onehot", {out_left, out_down, out_up}, 3'b000);
    check("rst_count", queue_count, 3'd0);
    check("rst_pulses", {dir_changed, drop}, 2'b00);
    rst = 1'b0;

    // 3-cycle glitch on down: no event, no drop
    down_pb = 1'b1;
    repeat (3) tick();
    down_pb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (drop || queue_count != 3'd0) seen = 1'b1;
    end
    check("glitch_no_event", seen, 1'b0);

    // Hold up: queued exactly after edge 7
    up_pb = 1'b1;
    repeat (7) tick();
    check("deb_count_edge6", queue_count, 3'd0);
    tick();
    check("deb_count_edge7", queue_count, 3'd1);
    check("deb_no_drop", drop, 1'b0);
    release_all();

    // Queue full: left accepted behind up, down dropped
    press(4'b0100);
    check("full_left_count", queue_count, 3'd2);
    check("full_left_drop", drop, 1'b0);
    press(4'b0010);
    check("full_down_drop", drop, 1'b1);
    check("full_down_count", queue_count, 3'd2);
    release_all();
    check("drop_single_pulse", drop, 1'b0);

    // Two steps drain in FIFO order
    do_step();
    check("step1_dir", dir, 2'b00);
    check("step1_out_up", {out_right, out_left, out_down, out_up}, 4'b0001);
    check("step1_changed", dir_changed, 1'b1);
    check("step1_count", queue_count, 3'd1);
    tick();
    check("step1_pulse_end", dir_changed, 1'b0);
    do_step();
    check("step2_dir", dir, 2'b10);
    check("step2_out_left", {out_right, out_left, out_down, out_up}, 4'b0100);
    check("step2_changed", dir_changed, 1'b1);
    check("step2_count", queue_count, 3'd0);

    // Idle step on empty queue
    do_step();
    check("idle_dir", dir, 2'b10);
    check("idle_no_change", dir_changed, 1'b0);

    // Reset, then reversal filter: right(11) -> left(10)
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst2_dir", dir, 2'b11);
    check("rst2_rev_dir", r_dir, 2'b11);
    press(4'b0100);
    check("rev0_drop", drop, 1'b1);
    check("rev0_count", queue_count, 3'd0);
    check("rev1_count", r_queue_count, 3'd1);
    check("rev1_no_drop", r_drop, 1'b0);
    release_all();
    do_step();
    check("rev1_dir", r_dir, 2'b10);
    check("rev1_changed", r_dir_changed, 1'b1);
    check("rev1_out_left", {r_right, r_left, r_down, r_up}, 4'b0100);
    check("rev0_dir_hold", dir, 2'b11);
    check("rev0_no_change", dir_changed, 1'b0);

    // Simultaneous up+left: up wins, left dropped
    press(4'b0101);
    check("simul_count", queue_count, 3'd1);
    check("simul_drop", drop, 1'b1);
    release_all();
    press(4'b0100);
    check("fill_count", queue_count, 3'd2);
    release_all();

    // Push down into full queue in the same cycle as a step
    down_pb = 1'b1;
    repeat (7) tick();
    do_step();
    check("pushpop_count", queue_count, 3'd2);
    check("pushpop_dir", dir, 2'b00);
    check("pushpop_changed", dir_changed, 1'b1);
    check("pushpop_no_drop", drop, 1'b0);
    release_all();
    do_step();
    check("fifo_dir1", dir, 2'b10);
    do_step();
    check("fifo_dir2", dir, 2'b01);
    check("fifo_empty", queue_count, 3'd0);

    // Mid-operation reset with a full queue; up held through reset release
    press(4'b0100);
    release_all();
    press(4'b0001);
    check("mid_count_full", queue_count, 3'd2);
    release_all();
    rst = 1'b1;
    up_pb = 1'b1;
    repeat (2) tick();
    check("mid_rst_count", queue_count, 3'd0);
    check("mid_rst_dir", dir, 2'b11);
    check("mid_rst_onehot", {out_right, out_left, out_down, out_up}, 4'b1000);
    rst = 1'b0;
    repeat (7) tick();
    check("held_edge6", queue_count, 3'd0);
    tick();
    check("held_fresh_press", queue_count, 3'd1);
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/direction_controller.md
# direction_controller

Parametrised successor to the pushbutton direction latch used by the game logic. Four asynchronous pushbuttons are synchronised, debounced and edge-detected, then filtered: no repeats, and no 180° reversals unless enabled. Accepted presses go into a small direction queue. The game tick (`step`) pops one entry per move into the registered current direction. Everything is clocked on one clock; there is no edge-triggered logic on button signals.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles needed to accept a level change; ≥1.
- `QUEUE_DEPTH`, 2, pending-direction entries; 1..4.
- `ALLOW_REVERSE`, 0, when 1, 180° reversals are accepted.
- `INIT_DIR`, 2'b11, direction loaded on reset.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `up_pb` in 1: raw button, asynchronous.
- `down_pb` in 1: raw button, asynchronous.
- `left_pb` in 1: raw button, asynchronous.
- `right_pb` in 1: raw button, asynchronous.
- `step` in 1: one-cycle move tick from the game timer.
- `dir` out 2: current direction. 00 = up, 01 = down, 10 = left, 11 = right; the reverse of any code is that code with bit0 flipped.
- `out_up` out 1: one-hot decode of `dir`, registered.
- `out_down` out 1: one-hot decode of `dir`, registered.
- `out_left` out 1: one-hot decode of `dir`, registered.
- `out_right` out 1: one-hot decode of `dir`, registered.
- `dir_changed` out 1: one-cycle pulse when `dir` takes a new value.
- `queue_count` out 3: number of pending entries, 0..QUEUE_DEPTH.
- `drop` out 1: one-cycle pulse when a press event is discarded.

## Operation
- Synchroniser: 2-FF chain per button, reset to 0.
- Debounce, per button: a counter runs while the synced level ≠ the stable level and clears when they are equal. When the count reaches DEBOUNCE_CYCLES, the stable level takes the synced level and the counter clears. Stable levels reset to 0.
- Press event: rising edge of a stable level; one cycle wide.
- Simultaneous press events in one cycle:
  - Priority is up > down > left > right.
  - The highest-priority event is the candidate; the losers are discarded and `drop` pulses.
- Tail: the newest queue entry if `queue_count` > 0, otherwise `dir`. It is evaluated on the pre-cycle state.
- Candidate rejection rules; each rejection pulses `drop` and leaves the queue unchanged:
  - (a) candidate equals the tail;
  - (b) ALLOW_REVERSE = 0 and candidate equals tail ^ 2'b01;
  - (c) queue is full and `step` is not popping this cycle.
- Otherwise the candidate is pushed.
- `step` with a non-empty queue: pop the head into `dir` and pulse `dir_changed`.
  - If the popped value equals `dir`, `dir_changed` still pulses; rule (a) prevents this from happening.
- `step` with an empty queue: `dir` holds and no pulse is produced.
- Push and pop in the same cycle: both take effect, and `queue_count` is unchanged. A full queue accepts the push in this case.
- Queue: circular buffer with read/write pointers that wrap modulo QUEUE_DEPTH. Order is FIFO.
- Reset values:
  - `dir` = INIT_DIR; one-hot outputs match INIT_DIR.
  - `queue_count` = 0; pointers = 0.
  - `dir_changed` = 0; `drop` = 0.
  - All sync, debounce and stable state = 0.
- Reset mid-operation:
  - All pending entries are lost.
  - A button held through reset release is seen as a fresh press once it is debounced.

## Timing
- Press latency: a button first sampled high at edge 0 and held gives a press event in the cycle after edge DEBOUNCE_CYCLES+2. `queue_count` (or `drop`) shows the result after edge DEBOUNCE_CYCLES+3.
- Release: needs DEBOUNCE_CYCLES stable low cycles and produces no event.
- A bounce shorter than DEBOUNCE_CYCLES produces no event.
- `step` sampled at edge N: `dir`, one-hot outputs and `dir_changed` update at N+1. `dir_changed` is high for exactly one cycle.
- `drop` is registered, one cycle after the rejected event; at most one pulse per cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, INIT_DIR=11 unless stated.
- Reset: assert `rst` for 3 cycles -> `dir`=11, `out_right`=1, the other one-hots 0, `queue_count`=0, no pulses.
- Debounce:
  - hold `up_pb` from edge 0 -> `queue_count`=1 after edge 7;
  - a 3-cycle glitch on `down_pb` -> no event, no `drop`.
- Reversal filter:
  - ALLOW_REVERSE=0, `dir`=11, press left -> `drop` pulses, `queue_count` stays 0.
  - ALLOW_REVERSE=1, same stimulus -> queued; on `step`, `dir`=10 and `dir_changed` pulses.
- Queue full:
  - press up, then left (tail=up), then down with no `step` -> third press dropped, `queue_count`=2.
  - two `step`s -> `dir`=00 then 10, one `dir_changed` per step.
- Simultaneous events:
  - press up and left in the same cycle -> up queued, `drop` pulses.
  - `step` in the same cycle as a push into a full queue -> push accepted, `queue_count` stays 2, FIFO order preserved.
- Idle step and mid-operation reset:
  - `step` on an empty queue -> `dir` unchanged, no `dir_changed`.
  - `rst` with `queue_count`=2 -> `queue_count`=0, `dir`=INIT_DIR.
